// File: rtl/hyperbus_if.sv
// HyperBus link signals between a controller PHY (master) and a device-side
// responder (slave); names match the responder's pin list.
interface hyperbus_if;
    logic       hyper_reset_ni;
    logic       hyper_cs_ni;
    logic       hyper_ck_i;
    logic       hyper_rwds_i;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;
    logic [7:0] hyper_dq_i;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;
    logic       busy_o;

    modport master (
        output hyper_reset_ni, hyper_cs_ni, hyper_ck_i, hyper_rwds_i, hyper_dq_i,
        input  hyper_rwds_o, hyper_rwds_oe_o, hyper_dq_o, hyper_dq_oe_o, busy_o
    );

    modport slave (
        input  hyper_reset_ni, hyper_cs_ni, hyper_ck_i, hyper_rwds_i, hyper_dq_i,
        output hyper_rwds_o, hyper_rwds_oe_o, hyper_dq_o, hyper_dq_oe_o, busy_o
    );
endinterface

// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder: CA decode, initial latency, word memory and
// ID0/CR0 register space, all driven from a beat clock that oversamples CK.
module hyperbus_responder #(
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned Latency      = 6,
    parameter bit          Always2x     = 1'b1,
    parameter int unsigned WrapWords    = 16,
    parameter logic [15:0] IdReg        = 16'h0c81,
    parameter logic [15:0] RstCr0       = 16'h8f1f
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    hyperbus_if.slave  bus
);
    localparam int unsigned WrapBits = $clog2(WrapWords);
    localparam int unsigned LatMult  = Always2x ? 2 : 1;
    localparam logic [7:0]  LatBeats = 8'(2 * Latency * LatMult);
    localparam int unsigned MemWords = 2 ** MemAddrWidth;

    localparam logic [MemAddrWidth-1:0] AddrOne = {{(MemAddrWidth-1){1'b0}}, 1'b1};
    localparam logic [WrapBits-1:0]     WrapOne = {{(WrapBits-1){1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CA        = 3'd1;
    localparam logic [2:0] ST_LAT       = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_READ      = 3'd4;
    localparam logic [2:0] ST_REG_WRITE = 3'd5;

    logic [2:0]              state_q, state_d;
    logic                    ck_q, ck_d;
    logic                    cs_q, cs_d;
    logic [39:0]             ca_q, ca_d;
    logic [2:0]              ca_cnt_q, ca_cnt_d;
    logic [7:0]              lat_cnt_q, lat_cnt_d;
    logic                    is_read_q, is_read_d;
    logic                    is_reg_q, is_reg_d;
    logic                    is_linear_q, is_linear_d;
    logic [MemAddrWidth-1:0] addr_q, addr_d;
    logic [31:0]             reg_addr_q, reg_addr_d;
    logic                    hi_q, hi_d;
    logic [15:0]             cr0_q, cr0_d;
    logic [7:0]              cr0_hi_q, cr0_hi_d;
    logic [7:0]              dq_o_q, dq_o_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    rwds_o_q, rwds_o_d;
    logic                    rwds_oe_q, rwds_oe_d;
    logic                    busy_q, busy_d;

    logic [15:0]             mem_q [0:MemWords-1];

    logic                    beat_s;
    logic [47:0]             ca_next_s;
    logic [31:0]             word_addr_s;
    logic [MemAddrWidth-1:0] addr_inc_s;
    logic [15:0]             reg_rd_s;
    logic [15:0]             rd_cur_s;
    logic [15:0]             rd_next_s;
    logic                    mem_we_hi_s;
    logic                    mem_we_lo_s;
    logic                    unused_ca_s;

    // Wrapped bursts only move inside the aligned WrapWords group.
    function automatic logic [MemAddrWidth-1:0] next_addr(
        input logic [MemAddrWidth-1:0] a,
        input logic                    linear
    );
        logic [MemAddrWidth-1:0] r;
        if (linear) begin
            r = a + AddrOne;
        end else begin
            r = a;
            r[WrapBits-1:0] = a[WrapBits-1:0] + WrapOne;
        end
        return r;
    endfunction

    // Beat detection, CA assembly and read-data selection.
    always_comb begin
        beat_s      = ~bus.hyper_cs_ni && (bus.hyper_ck_i != ck_q);
        ca_next_s   = {ca_q, bus.hyper_dq_i};
        word_addr_s = {ca_next_s[44:16], ca_next_s[2:0]};
        unused_ca_s = ^ca_next_s[15:3];
        addr_inc_s  = next_addr(addr_q, is_linear_q);
        if (reg_addr_q == 32'h0000_0000) begin
            reg_rd_s = IdReg;
        end else if (reg_addr_q == 32'h0000_0800) begin
            reg_rd_s = cr0_q;
        end else begin
            reg_rd_s = 16'h0000;
        end
        rd_cur_s  = is_reg_q ? reg_rd_s : mem_q[addr_q];
        rd_next_s = is_reg_q ? reg_rd_s : mem_q[addr_inc_s];
    end

    // Transaction sequencing and next values of the registered pins.
    always_comb begin
        state_d     = state_q;
        ck_d        = bus.hyper_ck_i;
        cs_d        = bus.hyper_cs_ni;
        ca_d        = ca_q;
        ca_cnt_d    = ca_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        is_read_d   = is_read_q;
        is_reg_d    = is_reg_q;
        is_linear_d = is_linear_q;
        addr_d      = addr_q;
        reg_addr_d  = reg_addr_q;
        hi_d        = hi_q;
        cr0_d       = cr0_q;
        cr0_hi_d    = cr0_hi_q;
        mem_we_hi_s = 1'b0;
        mem_we_lo_s = 1'b0;

        if (!bus.hyper_reset_ni) begin
            state_d = ST_IDLE;
            cr0_d   = RstCr0;
        end else if (bus.hyper_cs_ni) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_q) begin
                        state_d  = ST_CA;
                        ca_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CA: begin
                    if (beat_s) begin
                        ca_d = ca_next_s[39:0];
                        if (ca_cnt_q == 3'd5) begin
                            is_read_d   = ca_next_s[47];
                            is_reg_d    = ca_next_s[46];
                            is_linear_d = ca_next_s[45];
                            addr_d      = word_addr_s[MemAddrWidth-1:0];
                            reg_addr_d  = word_addr_s;
                            hi_d        = 1'b1;
                            ca_cnt_d    = 3'd0;
                            if (ca_next_s[46] && !ca_next_s[47]) begin
                                state_d = ST_REG_WRITE;
                            end else begin
                                state_d   = ST_LAT;
                                lat_cnt_d = LatBeats;
                            end
                        end else begin
                            ca_cnt_d = ca_cnt_q + 3'd1;
                        end
                    end else begin
                        ca_d = ca_q;
                    end
                end
                ST_LAT: begin
                    if (beat_s) begin
                        lat_cnt_d = lat_cnt_q - 8'd1;
                        if (lat_cnt_q == 8'd1) begin
                            state_d = is_read_q ? ST_READ : ST_WRITE;
                        end else begin
                            state_d = ST_LAT;
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q;
                    end
                end
                ST_WRITE: begin
                    if (beat_s) begin
                        hi_d = ~hi_q;
                        if (hi_q) begin
                            mem_we_hi_s = ~bus.hyper_rwds_i;
                        end else begin
                            mem_we_lo_s = ~bus.hyper_rwds_i;
                            addr_d      = addr_inc_s;
                        end
                    end else begin
                        hi_d = hi_q;
                    end
                end
                ST_READ: begin
                    if (beat_s) begin
                        hi_d = ~hi_q;
                        if (!hi_q) begin
                            addr_d = addr_inc_s;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        hi_d = hi_q;
                    end
                end
                ST_REG_WRITE: begin
                    if (beat_s && (ca_cnt_q == 3'd0)) begin
                        cr0_hi_d = bus.hyper_dq_i;
                        ca_cnt_d = 3'd1;
                    end else if (beat_s && (ca_cnt_q == 3'd1)) begin
                        cr0_d    = {cr0_hi_q, bus.hyper_dq_i};
                        ca_cnt_d = 3'd2;
                    end else begin
                        ca_cnt_d = ca_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        dq_o_d    = 8'h00;
        dq_oe_d   = 1'b0;
        rwds_o_d  = 1'b0;
        rwds_oe_d = 1'b0;
        case (state_d)
            ST_CA: begin
                rwds_oe_d = 1'b1;
                rwds_o_d  = Always2x;
            end
            ST_LAT: begin
                rwds_oe_d = is_read_d;
            end
            ST_READ: begin
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                // rwds_o tags which half of the word is currently on dq_o.
                if (state_q != ST_READ) begin
                    dq_o_d   = rd_cur_s[15:8];
                    rwds_o_d = 1'b1;
                end else if (beat_s && hi_q) begin
                    dq_o_d   = rd_cur_s[7:0];
                    rwds_o_d = 1'b0;
                end else if (beat_s) begin
                    dq_o_d   = rd_next_s[15:8];
                    rwds_o_d = 1'b1;
                end else begin
                    dq_o_d   = dq_o_q;
                    rwds_o_d = rwds_o_q;
                end
            end
            default: begin
                dq_oe_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ck_q        <= 1'b0;
            cs_q        <= 1'b1;
            ca_q        <= 40'h00_0000_0000;
            ca_cnt_q    <= 3'd0;
            lat_cnt_q   <= 8'd0;
            is_read_q   <= 1'b0;
            is_reg_q    <= 1'b0;
            is_linear_q <= 1'b0;
            addr_q      <= {MemAddrWidth{1'b0}};
            reg_addr_q  <= 32'h0000_0000;
            hi_q        <= 1'b1;
            cr0_q       <= RstCr0;
            cr0_hi_q    <= 8'h00;
            dq_o_q      <= 8'h00;
            dq_oe_q     <= 1'b0;
            rwds_o_q    <= 1'b0;
            rwds_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ck_q        <= ck_d;
            cs_q        <= cs_d;
            ca_q        <= ca_d;
            ca_cnt_q    <= ca_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            is_read_q   <= is_read_d;
            is_reg_q    <= is_reg_d;
            is_linear_q <= is_linear_d;
            addr_q      <= addr_d;
            reg_addr_q  <= reg_addr_d;
            hi_q        <= hi_d;
            cr0_q       <= cr0_d;
            cr0_hi_q    <= cr0_hi_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            rwds_o_q    <= rwds_o_d;
            rwds_oe_q   <= rwds_oe_d;
            busy_q      <= busy_d;
        end
    end

    // Byte-granular memory writes; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_hi_s) begin
            mem_q[addr_q][15:8] <= bus.hyper_dq_i;
        end
        if (mem_we_lo_s) begin
            mem_q[addr_q][7:0] <= bus.hyper_dq_i;
        end
    end

    assign bus.hyper_dq_o      = dq_o_q;
    assign bus.hyper_dq_oe_o   = dq_oe_q;
    assign bus.hyper_rwds_o    = rwds_o_q;
    assign bus.hyper_rwds_oe_o = rwds_oe_q;
    assign bus.busy_o          = busy_q;
endmodule

// File: tb/tb_hyperbus_responder.sv
// Directed bench for hyperbus_responder: one CK toggle per beat-clock cycle,
// inputs driven and outputs sampled on the falling clock edge.
module tb_hyperbus_responder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    logic [7:0] obs_dq_o;
    logic       obs_dq_oe;
    logic       obs_rwds_o;
    logic       obs_rwds_oe;
    logic [7:0] wbuf [8];
    logic       mbuf [8];
    logic [7:0] rbuf [8];
    logic       rwbuf [8];

    hyperbus_if hb ();

    hyperbus_responder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (hb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample pins as left by earlier beats, then present one beat.
    task automatic drive_beat(input logic [7:0] d, input logic m);
        @(negedge clk);
        obs_dq_o    = hb.hyper_dq_o;
        obs_dq_oe   = hb.hyper_dq_oe_o;
        obs_rwds_o  = hb.hyper_rwds_o;
        obs_rwds_oe = hb.hyper_rwds_oe_o;
        hb.hyper_dq_i   = d;
        hb.hyper_rwds_i = m;
        hb.hyper_ck_i   = ~hb.hyper_ck_i;
    endtask

    task automatic start_cs();
        @(negedge clk);
        hb.hyper_cs_ni = 1'b0;
    endtask

    task automatic end_cs();
        @(negedge clk);
        hb.hyper_cs_ni = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", {31'd0, hb.busy_o}, 32'd0);
        check_eq("idle_oe", {30'd0, hb.hyper_dq_oe_o, hb.hyper_rwds_oe_o}, 32'd0);
    endtask

    task automatic send_ca(input logic rd, input logic rg, input logic lin, input logic [31:0] a);
        logic [47:0] ca;
        ca = {rd, rg, lin, a[31:3], 13'h0000, a[2:0]};
        for (int i = 0; i < 6; i++) begin
            drive_beat(ca[47-8*i -: 8], 1'b0);
            if (i == 2) begin
                check_eq("ca_rwds", {30'd0, obs_rwds_oe, obs_rwds_o}, 32'd3);
            end
        end
    endtask

    task automatic head(input logic rd, input logic rg, input logic lin, input logic [31:0] a);
        start_cs();
        send_ca(rd, rg, lin, a);
        for (int i = 1; i <= 24; i++) begin
            drive_beat(8'h00, 1'b0);
            if (i == 2) begin
                check_eq("lat_rwds_oe", {31'd0, obs_rwds_oe}, {31'd0, rd});
                check_eq("lat_rwds_o", {31'd0, obs_rwds_o}, 32'd0);
            end
            if (i == 24) begin
                check_eq("lat23_dq_oe", {31'd0, obs_dq_oe}, 32'd0);
            end
        end
    endtask

    task automatic write_txn(input logic [31:0] a, input logic lin, input int n);
        head(1'b0, 1'b0, lin, a);
        for (int i = 0; i < n; i++) begin
            drive_beat(wbuf[i], mbuf[i]);
        end
        end_cs();
    endtask

    task automatic read_data(input int n);
        for (int i = 0; i < n; i++) begin
            drive_beat(8'h00, 1'b0);
            rbuf[i]  = obs_dq_o;
            rwbuf[i] = obs_rwds_o;
            if (i == 0) begin
                check_eq("lat24_dq_oe", {31'd0, obs_dq_oe}, 32'd1);
            end
        end
    endtask

    task automatic read_txn(input logic [31:0] a, input logic rg, input logic lin, input int n);
        head(1'b1, rg, lin, a);
        read_data(n);
        end_cs();
    endtask

    // Expected bytes packed MSB first; rwds alternates 1,0 starting on a high byte.
    task automatic cmp_read(input string tag, input int n, input logic [63:0] exp);
        logic [7:0] eb;
        for (int i = 0; i < n; i++) begin
            eb = exp[63-8*i -: 8];
            check_eq($sformatf("%s_dq%0d", tag, i), {24'd0, rbuf[i]}, {24'd0, eb});
            check_eq($sformatf("%s_rwds%0d", tag, i), {31'd0, rwbuf[i]}, {31'd0, ~i[0]});
        end
    endtask

    task automatic set_w(input int i, input logic [7:0] d, input logic m);
        wbuf[i] = d;
        mbuf[i] = m;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        hb.hyper_reset_ni = 1'b1;
        hb.hyper_cs_ni    = 1'b1;
        hb.hyper_ck_i     = 1'b0;
        hb.hyper_rwds_i   = 1'b0;
        hb.hyper_dq_i     = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {19'd0, hb.busy_o, hb.hyper_dq_oe_o, hb.hyper_rwds_oe_o,
                              hb.hyper_rwds_o, hb.hyper_dq_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, hb.busy_o}, 32'd0);

        // Linear write then read back.
        set_w(0, 8'hAB, 1'b0); set_w(1, 8'hCD, 1'b0); set_w(2, 8'h12, 1'b0); set_w(3, 8'h34, 1'b0);
        write_txn(32'h10, 1'b1, 4);
        read_txn(32'h10, 1'b0, 1'b1, 4);
        cmp_read("lin", 4, 64'hABCD1234_00000000);

        // Masked low byte keeps the old value.
        set_w(0, 8'hFF, 1'b0); set_w(1, 8'hFF, 1'b0);
        write_txn(32'h20, 1'b1, 2);
        set_w(0, 8'h55, 1'b0); set_w(1, 8'h66, 1'b1);
        write_txn(32'h20, 1'b1, 2);
        read_txn(32'h20, 1'b0, 1'b1, 2);
        cmp_read("mask", 2, 64'h55FF0000_00000000);

        // Wrapped read crosses the 16-word group boundary back to 0x10.
        set_w(0, 8'hA1, 1'b0); set_w(1, 8'hB2, 1'b0); set_w(2, 8'hC3, 1'b0); set_w(3, 8'hD4, 1'b0);
        write_txn(32'h1E, 1'b1, 4);
        read_txn(32'h1E, 1'b0, 1'b0, 8);
        cmp_read("wrap", 8, 64'hA1B2C3D4_ABCD1234);

        // Register write has no latency; reads repeat the selected register.
        start_cs();
        send_ca(1'b0, 1'b1, 1'b1, 32'h800);
        drive_beat(8'h8F, 1'b1);
        drive_beat(8'h17, 1'b1);
        drive_beat(8'hEE, 1'b0);
        end_cs();
        read_txn(32'h800, 1'b1, 1'b1, 4);
        cmp_read("cr0", 4, 64'h8F178F17_00000000);
        read_txn(32'h000, 1'b1, 1'b1, 2);
        cmp_read("id0", 2, 64'h0C810000_00000000);
        read_txn(32'h004, 1'b1, 1'b1, 2);
        cmp_read("regx", 2, 64'h00000000_00000000);

        // Device reset restores CR0.
        @(negedge clk);
        hb.hyper_reset_ni = 1'b0;
        @(negedge clk);
        hb.hyper_reset_ni = 1'b1;
        read_txn(32'h800, 1'b1, 1'b1, 2);
        cmp_read("cr0rst", 2, 64'h8F1F0000_00000000);

        // Abort in the middle of CA, then a clean transaction.
        start_cs();
        drive_beat(8'h80, 1'b0);
        drive_beat(8'h00, 1'b0);
        drive_beat(8'h00, 1'b0);
        end_cs();
        read_txn(32'h10, 1'b0, 1'b1, 2);
        cmp_read("abort", 2, 64'hABCD0000_00000000);

        // Asynchronous reset during a read burst.
        head(1'b1, 1'b0, 1'b1, 32'h10);
        read_data(2);
        @(negedge clk);
        check_eq("pre_rst_dq_oe", {31'd0, hb.hyper_dq_oe_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        hb.hyper_cs_ni = 1'b1;
        #1;
        check_eq("async_rst_outs", {19'd0, hb.busy_o, hb.hyper_dq_oe_o, hb.hyper_rwds_oe_o,
                                    hb.hyper_rwds_o, hb.hyper_dq_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_txn(32'h10, 1'b0, 1'b1, 2);
        cmp_read("retain", 2, 64'hABCD0000_00000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hyperbus_responder.md
Name: hyperbus_responder

Overview:
- Synthesizable HyperBus device-side responder, i.e. the memory end of the link driven by the HyperBus controller PHY.
- Decodes the 48-bit command/address (CA), applies initial read/write latency, and serves reads and writes from an internal word-addressed memory plus an ID0/CR0 register space.
- Used as an on-chip loopback target for FPGA/ASIC bring-up and as a synthesizable stand-in for HyperRAM in regression benches.
- Runs on a beat clock at ≥2× the HyperBus CK rate; CK transitions are detected synchronously.

Parameters:
- MemAddrWidth, 10: word-address width; memory holds 2**MemAddrWidth 16-bit words.
- Latency, 6: initial latency in CK cycles.
- Always2x, 1: 1 means fixed double latency is always used and signalled via RWDS high during CA.
- WrapWords, 16: wrapped-burst group size in words (power of two, 8/16/32/64).
- IdReg, 16'h0c81: value returned by ID0.
- RstCr0, 16'h8f1f: reset value of CR0.

Ports:
- clk_i  in  1  beat clock
- rst_ni  in  1  asynchronous active-low reset
- hyper_reset_ni  in  1  device reset from controller, sampled synchronously, active-low
- hyper_cs_ni  in  1  chip select, active-low
- hyper_ck_i  in  1  HyperBus CK, sampled
- hyper_rwds_i  in  1  write mask from controller (1 = byte masked)
- hyper_rwds_o  out  1  RWDS drive value
- hyper_rwds_oe_o  out  1  RWDS output enable
- hyper_dq_i  in  8  DQ from controller
- hyper_dq_o  out  8  DQ drive value
- hyper_dq_oe_o  out  1  DQ output enable
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i; rst_ni is asynchronous, active-low. On reset, state=IDLE, CR0=RstCr0, all outputs 0, and the ck_q edge register is cleared. Memory contents are not reset.
- hyper_reset_ni low: synchronous return to IDLE next cycle, CR0=RstCr0, outputs 0.
- Beat: a cycle in which hyper_cs_ni=0 and hyper_ck_i != ck_q, where ck_q is hyper_ck_i registered. One byte is consumed or produced per beat.
- CS high in any state: go to IDLE next cycle and deassert all OEs. This applies on every cycle and has priority over beat processing.
- IDLE: on hyper_cs_ni falling, go to CA with the beat counter at 0.
- CA:
  - Shift in 6 bytes MSB first.
  - While in CA: rwds_oe=1, rwds_o=Always2x.
  - After the 6th beat, decode:
    - CA[47]=read.
    - CA[46]=register space.
    - CA[45]=linear (0 = wrapped).
    - Word address = {CA[44:16],CA[2:0]} truncated to MemAddrWidth.
  - Next state:
    - Register write → REG_WRITE, with zero latency.
    - Otherwise → LATENCY, loaded with L = 2*Latency*(Always2x?2:1) beats (24 by default).
- LATENCY:
  - Count down one per beat.
  - Read: rwds_oe=1, rwds_o=0.
  - Write: rwds_oe=0.
  - On the beat that reaches 0: a write goes to WRITE; a read goes to READ and loads the first byte into the output register in that cycle.
- WRITE:
  - Bytes alternate high byte then low byte of the current word.
  - A byte is written only if hyper_rwds_i=0 on its beat (per-byte enables).
  - The address advances after each low byte.
  - An odd trailing byte before CS rises commits alone.
- READ:
  - dq_oe=1 and rwds_oe=1.
  - Output registers update in the cycle after each beat.
  - rwds_o=1 while dq_o carries a high byte and 0 while it carries a low byte.
  - The address advances after each low byte.
- Address increment:
  - Linear: wraps modulo 2**MemAddrWidth.
  - Wrapped: the low log2(WrapWords) bits increment modulo WrapWords; upper bits hold.
- Register space, selected by word address bit 11:
  - 0 = ID0, 1 = CR0.
  - Reads return the selected register, or 0 for any other address bit pattern, then repeat the same value.
  - REG_WRITE takes 2 bytes (high byte first) into CR0; rwds_i masking does not apply; further beats are ignored until CS rises.
  - Register reads use normal latency.
- Simultaneous CS rise and beat: the beat is dropped and no memory write occurs.

Test Plan:
- Linear write: CA=write, linear, address 0x10; data AB CD 12 34 with rwds_i=0 -> mem[0x10]=0xABCD, mem[0x11]=0x1234. Read back the same address -> dq bytes AB,CD,12,34 with rwds_o sequence 1,0,1,0, first byte appearing after exactly 24 latency beats.
- Masked write: mem[0x20]=0xFFFF, then write 0x5566 with rwds_i=1 on the low byte -> mem[0x20]=0x55FF.
- Wrapped read: WrapWords=16, start address 0x1E, read 4 words -> words 0x1E, 0x1F, 0x10, 0x11 are returned.
- Register access: register write CR0=0x8f17 -> register read at 0x800 returns 8F,17; register read at 0x000 returns IdReg (0C,81).
- Abort mid-CA: CS rises after 3 CA bytes -> state IDLE the next cycle, all OEs 0. A following full transaction decodes correctly.
- Reset mid-read: pulse rst_ni low during READ -> all outputs 0 immediately and busy_o=0. Memory retains previously written 0xABCD at address 0x10.
